// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: each beat is steered by in_sel into a
// per-channel 2-entry FIFO; illegal selects are consumed and counted.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [N_OUT*WIDTH-1:0]   out_data,
    output logic [15:0]              drop_count
);

    localparam int SEL_SPAN = 1 << SEL_W;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]          count_p1 [N_OUT];
    logic [WIDTH-1:0]    head_p1  [N_OUT];
    logic [WIDTH-1:0]    tail_p1  [N_OUT];
    logic [SEL_SPAN-1:0] legal;
    logic [SEL_SPAN-1:0] blocked;
    logic [N_OUT-1:0]    push;
    logic [N_OUT-1:0]    pop;
    logic                accept;

    // Select decode is widened to the full select range so that out-of-range
    // codes look like an always-ready, never-stored destination.
    for (genvar j = 0; j < SEL_SPAN; j++) begin : g_sel
        if (j < N_OUT) begin : g_live
            assign legal[j]   = 1'b1;
            assign blocked[j] = (count_p1[j] == 2'd2);
        end else begin : g_dead
            assign legal[j]   = 1'b0;
            assign blocked[j] = 1'b0;
        end
    end

    assign in_ready = ~blocked[in_sel];
    assign accept   = in_valid & in_ready;

    // Input -> channel FIFO registers
    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        assign push[i] = accept & legal[in_sel] & (in_sel == SEL_W'(i));
        assign pop[i]  = out_valid[i] & out_ready[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                count_p1[i] <= 2'd0;
                head_p1[i]  <= '0;
                tail_p1[i]  <= '0;
            end else begin
                case ({push[i], pop[i]})
                    2'b11: head_p1[i] <= in_data;
                    2'b01: begin
                        head_p1[i]  <= tail_p1[i];
                        count_p1[i] <= count_p1[i] - 2'd1;
                    end
                    2'b10: begin
                        if (count_p1[i] == 2'd0) head_p1[i] <= in_data;
                        else                     tail_p1[i] <= in_data;
                        count_p1[i] <= count_p1[i] + 2'd1;
                    end
                    default: ;
                endcase
            end
        end

        assign out_valid[i]                = (count_p1[i] != 2'd0);
        assign out_data[i*WIDTH +: WIDTH]  = head_p1[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_count <= 16'd0;
        else if (accept && !legal[in_sel])
            drop_count <= sat_inc(drop_count);
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios on a 4-channel and a
// 3-channel instance, plus randomized traffic against a queue-based model.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [7:0]  in_data4 = '0;
    logic [1:0]  in_sel4 = '0;
    logic [3:0]  out_valid4;
    logic [3:0]  out_ready4 = '0;
    logic [31:0] out_data4;
    logic [15:0] drop4;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [7:0]  in_data3 = '0;
    logic [1:0]  in_sel3 = '0;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3 = '0;
    logic [23:0] out_data3;
    logic [15:0] drop3;

    int tests = 0;
    int fails = 0;

    logic [7:0] q [4][$];

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8), .N_OUT(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_sel(in_sel4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .drop_count(drop4)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .drop_count(drop3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        in_valid4 = 1'b0;
        in_valid3 = 1'b0;
        #1;
        tests++;
        if (out_valid4 !== 4'b0) begin
            fails++; $display("FAIL reset_valid4 got %b want 0000", out_valid4);
        end
        tests++;
        if (drop4 !== 16'd0) begin
            fails++; $display("FAIL reset_drop4 got %h want 0000", drop4);
        end
        tests++;
        if (out_data4 !== 32'd0) begin
            fails++; $display("FAIL reset_data4 got %h want 0", out_data4);
        end
        tests++;
        if (out_valid3 !== 3'b0 || drop3 !== 16'd0) begin
            fails++; $display("FAIL reset_dut3 got valid=%b drop=%h want 0/0", out_valid3, drop3);
        end
        for (int s = 0; s < 4; s++) begin
            in_sel4 = 2'(s);
            in_sel3 = 2'(s);
            #1;
            tests++;
            if (in_ready4 !== 1'b1 || in_ready3 !== 1'b1) begin
                fails++; $display("FAIL reset_ready sel=%0d got %b/%b want 1/1", s, in_ready4, in_ready3);
            end
        end
    endtask

    task automatic test_routing();
        logic [7:0] tbl [4];
        tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44;
        out_ready4 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1'b1;
            in_sel4   = 2'(k);
            in_data4  = tbl[k];
            #1;
            tests++;
            if (in_ready4 !== 1'b1) begin
                fails++; $display("FAIL route_ready%0d got %b want 1", k, in_ready4);
            end
            tick();
            tests++;
            if (out_valid4 !== (4'b1 << k) || out_data4[k*8 +: 8] !== tbl[k]) begin
                fails++;
                $display("FAIL route_ch%0d got valid=%b data=%h want valid=%b data=%h",
                         k, out_valid4, out_data4[k*8 +: 8], 4'b1 << k, tbl[k]);
            end
        end
        in_valid4 = 1'b0;
        tick();
        tests++;
        if (out_valid4 !== 4'b0) begin
            fails++; $display("FAIL route_drain got %b want 0000", out_valid4);
        end
    endtask

    task automatic test_backpressure();
        out_ready4 = 4'b1011;
        in_valid4  = 1'b1;
        in_sel4    = 2'd2;
        in_data4   = 8'hA0;
        #1;
        tests++;
        if (in_ready4 !== 1'b1) begin
            fails++; $display("FAIL bp_ready_a0 got %b want 1", in_ready4);
        end
        tick();
        in_data4 = 8'hA1;
        #1;
        tests++;
        if (in_ready4 !== 1'b1) begin
            fails++; $display("FAIL bp_ready_a1 got %b want 1", in_ready4);
        end
        tick();
        in_data4 = 8'hA2;
        #1;
        tests++;
        if (in_ready4 !== 1'b0 || out_valid4[2] !== 1'b1 || out_data4[23:16] !== 8'hA0) begin
            fails++;
            $display("FAIL bp_full got ready=%b v=%b head=%h want 0/1/a0",
                     in_ready4, out_valid4[2], out_data4[23:16]);
        end
        tick();
        out_ready4 = 4'hF;
        #1;
        tests++;
        if (in_ready4 !== 1'b0 || out_data4[23:16] !== 8'hA0) begin
            fails++; $display("FAIL bp_pop_cycle got ready=%b head=%h want 0/a0", in_ready4, out_data4[23:16]);
        end
        tick();
        tests++;
        if (in_ready4 !== 1'b1 || out_data4[23:16] !== 8'hA1) begin
            fails++; $display("FAIL bp_after_pop got ready=%b head=%h want 1/a1", in_ready4, out_data4[23:16]);
        end
        tick();
        in_valid4 = 1'b0;
        #1;
        tests++;
        if (out_valid4 !== 4'b0100 || out_data4[23:16] !== 8'hA2) begin
            fails++; $display("FAIL bp_a2 got valid=%b head=%h want 0100/a2", out_valid4, out_data4[23:16]);
        end
        tick();
        tests++;
        if (out_valid4 !== 4'b0) begin
            fails++; $display("FAIL bp_drain got %b want 0000", out_valid4);
        end
    endtask

    task automatic test_isolation();
        out_ready4 = 4'b1101;
        in_valid4  = 1'b1;
        in_sel4    = 2'd1;
        in_data4   = 8'h61;
        tick();
        in_data4   = 8'h62;
        tick();
        in_sel4    = 2'd3;
        in_data4   = 8'h55;
        #1;
        tests++;
        if (in_ready4 !== 1'b1) begin
            fails++; $display("FAIL iso_ready got %b want 1", in_ready4);
        end
        tick();
        in_valid4 = 1'b0;
        #1;
        tests++;
        if (out_valid4 !== 4'b1010 || out_data4[31:24] !== 8'h55 || out_data4[15:8] !== 8'h61) begin
            fails++;
            $display("FAIL iso_out got valid=%b ch3=%h ch1=%h want 1010/55/61",
                     out_valid4, out_data4[31:24], out_data4[15:8]);
        end
        out_ready4 = 4'hF;
        tick();
        tests++;
        if (out_valid4 !== 4'b0010 || out_data4[15:8] !== 8'h62) begin
            fails++; $display("FAIL iso_ch1_next got valid=%b ch1=%h want 0010/62", out_valid4, out_data4[15:8]);
        end
        tick();
    endtask

    task automatic test_random();
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] r;
        logic       exp_ready;
        logic [3:0] exp_valid;
        for (int c = 0; c < 4; c++) q[c].delete();
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            r = 4'($urandom);
            in_valid4  = v;
            in_sel4    = s;
            in_data4   = d;
            out_ready4 = r;
            #1;
            exp_ready = (q[s].size() < 2);
            for (int c = 0; c < 4; c++) exp_valid[c] = (q[c].size() != 0);
            tests++;
            if (in_ready4 !== exp_ready) begin
                fails++; $display("FAIL rand_ready cyc=%0d got %b want %b", n, in_ready4, exp_ready);
            end
            tests++;
            if (out_valid4 !== exp_valid) begin
                fails++; $display("FAIL rand_valid cyc=%0d got %b want %b", n, out_valid4, exp_valid);
            end
            for (int c = 0; c < 4; c++) begin
                if (q[c].size() != 0) begin
                    tests++;
                    if (out_data4[c*8 +: 8] !== q[c][0]) begin
                        fails++;
                        $display("FAIL rand_data cyc=%0d ch=%0d got %h want %h",
                                 n, c, out_data4[c*8 +: 8], q[c][0]);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                if (r[c] && q[c].size() != 0) void'(q[c].pop_front());
            if (v && exp_ready) q[s].push_back(d);
            tick();
        end
        in_valid4  = 1'b0;
        out_ready4 = 4'hF;
        tick();
        tick();
        tests++;
        if (out_valid4 !== 4'b0 || drop4 !== 16'd0) begin
            fails++; $display("FAIL rand_end got valid=%b drop=%h want 0/0", out_valid4, drop4);
        end
    endtask

    task automatic test_mid_reset();
        out_ready4 = 4'b0;
        in_valid4  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sel4  = 2'(k / 2);
            in_data4 = 8'(8'hC0 + k);
            tick();
        end
        in_sel4 = 2'd0;
        #1;
        tests++;
        if (out_valid4 !== 4'b0011 || in_ready4 !== 1'b0) begin
            fails++; $display("FAIL mrst_fill got valid=%b ready=%b want 0011/0", out_valid4, in_ready4);
        end
        rst      = 1'b1;
        in_sel4  = 2'd2;
        in_data4 = 8'h77;
        tick();
        rst       = 1'b0;
        in_valid4 = 1'b0;
        in_sel4   = 2'd0;
        #1;
        tests++;
        if (out_valid4 !== 4'b0 || out_data4 !== 32'd0 || in_ready4 !== 1'b1) begin
            fails++;
            $display("FAIL mrst_clear got valid=%b data=%h ready=%b want 0/0/1", out_valid4, out_data4, in_ready4);
        end
        tick();
        tests++;
        if (out_valid4 !== 4'b0) begin
            fails++; $display("FAIL mrst_nostore got valid=%b want 0000", out_valid4);
        end
    endtask

    task automatic test_illegal();
        out_ready3 = 3'b111;
        tests++;
        if (drop3 !== 16'd0) begin
            fails++; $display("FAIL ill_start got %h want 0000", drop3);
        end
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        for (int k = 0; k < 5; k++) begin
            in_data3 = 8'($urandom);
            #1;
            tests++;
            if (in_ready3 !== 1'b1) begin
                fails++; $display("FAIL ill_ready%0d got %b want 1", k, in_ready3);
            end
            tick();
            tests++;
            if (out_valid3 !== 3'b0) begin
                fails++; $display("FAIL ill_valid%0d got %b want 000", k, out_valid3);
            end
        end
        tests++;
        if (drop3 !== 16'd5) begin
            fails++; $display("FAIL ill_count got %0d want 5", drop3);
        end
        for (int k = 5; k < 65534; k++) tick();
        tests++;
        if (drop3 !== 16'hFFFE) begin
            fails++; $display("FAIL ill_fffe got %h want fffe", drop3);
        end
        tick();
        tests++;
        if (drop3 !== 16'hFFFF) begin
            fails++; $display("FAIL ill_ffff got %h want ffff", drop3);
        end
        tick();
        in_valid3 = 1'b0;
        tests++;
        if (drop3 !== 16'hFFFF) begin
            fails++; $display("FAIL ill_sat got %h want ffff", drop3);
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_isolation();
        test_random();
        test_mid_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
